// File: rtl/dff_response_checker.sv
// -----------------------------------------------------------------------------
// dff_response_checker
//   On-chip monitor for a sync-clear register (or an N-deep register pipe).
//   It taps the DUT's d / sync-reset / q and runs a reference pipe of LATENCY
//   stages. Every valid q_obs is compared with the prediction, and pass/fail
//   statistics are accumulated.
//
// Ports
//   clk, rst          checker clock and synchronous active-high checker reset
//   en                level-sensitive checking enable
//   d_obs, rst_obs    observed DUT data input and DUT synchronous clear
//   q_obs             observed DUT output
//   clr_stats         one-cycle pulse that zeroes counters and sticky flags
//   busy              state is FILL or CHECK (registered)
//   error             sticky, set on the first mismatch
//   mismatch_count    saturating count of mismatching compares
//   compare_count     saturating count of compares performed
//   first_fail_*      compare index, expected value and q_obs at first mismatch
// -----------------------------------------------------------------------------
module dff_response_checker #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d_obs,
  input  logic             rst_obs,
  input  logic [WIDTH-1:0] q_obs,
  input  logic             clr_stats,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] compare_count,
  output logic [CNT_W-1:0] first_fail_cycle,
  output logic [WIDTH-1:0] first_fail_exp,
  output logic [WIDTH-1:0] first_fail_got
);

  typedef enum logic [1:0] {IDLE, FILL, CHECK} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e                          state_q;
  logic [LATENCY-1:0][WIDTH-1:0]   exp_q;
  logic [LATENCY-1:0]              vld_pipe_q;

  logic             do_cmp;
  logic             miss;
  logic [WIDTH-1:0] exp_tail;

  assign exp_tail = exp_q[LATENCY-1];
  assign do_cmp   = en && (state_q == CHECK) && vld_pipe_q[LATENCY-1];
  assign miss     = (q_obs != exp_tail);

  // Reference pipe + FSM. A DUT-side clear zeroes the value entering stage 0
  // and every stage in flight, since each DUT stage clears on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      exp_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      if (en) begin
        exp_q[0]      <= rst_obs ? '0 : d_obs;
        vld_pipe_q[0] <= 1'b1;
        for (int k = 1; k < LATENCY; k++) begin
          exp_q[k]      <= rst_obs ? '0 : exp_q[k-1];
          vld_pipe_q[k] <= vld_pipe_q[k-1];
        end
      end else begin
        vld_pipe_q <= '0;
      end

      if (!en) begin
        state_q <= IDLE;
        busy    <= 1'b0;
      end else begin
        busy <= 1'b1;
        unique case (state_q)
          IDLE:    state_q <= FILL;
          FILL:    if (vld_pipe_q[LATENCY-1]) state_q <= CHECK;
          CHECK:   state_q <= CHECK;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Statistics. clr_stats wins over a compare landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      error            <= 1'b0;
      mismatch_count   <= '0;
      compare_count    <= '0;
      first_fail_cycle <= '0;
      first_fail_exp   <= '0;
      first_fail_got   <= '0;
    end else if (do_cmp) begin
      if (compare_count != CNT_MAX) compare_count <= compare_count + 1'b1;
      if (miss) begin
        if (mismatch_count != CNT_MAX) mismatch_count <= mismatch_count + 1'b1;
        if (!error) begin
          error            <= 1'b1;
          first_fail_cycle <= compare_count;
          first_fail_exp   <= exp_tail;
          first_fail_got   <= q_obs;
        end
      end
    end
  end

endmodule
